// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - state_e : FSM state encoding (RUN, LOAD_STALL, FLUSH, MEM_WAIT)
//   - OP_*    : MIPS primary opcodes relevant to hazard detection
//   - decode_uses_rt() : 1 when the ID-stage instruction reads rt as a source
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2,
      MEM_WAIT   = 2'd3
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;

   // R-type ALU ops, stores (rt is the data) and the two compare-branches read
   // rt; everything else (lw, addi, ...) writes it or ignores it.
   function automatic logic decode_uses_rt(input logic [5:0] opcode);
      return opcode inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};
   endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector between the ID and EX stages.
// Ports:
//   opcode, rs, rt : fields of the instruction sitting in ID
//   mem_read       : instruction in EX is a load
//   ex_rt          : destination register of that load
//   load_use       : ID instruction needs the load result next cycle
// -----------------------------------------------------------------------------
module load_use_detect
   import hazard_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       mem_read,
   input  logic [4:0] ex_rt,
   output logic       load_use
);

   logic uses_rt;

   assign uses_rt = decode_uses_rt(opcode);

   // $zero is never a real dependency: a load into r0 is discarded.
   assign load_use = mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage MIPS core: one-bubble
// load-use stalls, wrong-path flush after a taken branch, and a full-pipeline
// freeze while a multi-cycle data-memory access is outstanding.
//
// Parameters:
//   FLUSH_CYCLES : cycles IF/ID and ID/EX are flushed per taken branch (1..7)
//   MEM_TIMEOUT  : freeze length at which mem_timeout is raised
//   CNT_W        : width of the optional statistics counters
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   IF_ID_opcode/rs/rt    : instruction in ID
//   ID_EX_MemRead/rt      : load in EX and its destination
//   EX_MEM_BranchTaken    : branch resolved taken in MEM
//   dmem_req, dmem_ready  : data-memory access active / completing
//   PCWrite, IF_ID_Write  : PC and IF/ID load enables
//   Hazard                : bubble request to the ID control unit
//   IF_Flush, ID_EX_Flush : clear IF/ID and ID/EX
//   pipe_freeze           : hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout           : sticky memory-wait timeout flag
//   state_out             : current FSM state
//
// Optional build macro HAZARD_STATS_EN adds saturating counters
// load_stall_cnt, flush_cnt and freeze_cnt (CNT_W bits each).
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 64,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       IF_ID_opcode,
   input  logic [4:0]       IF_ID_rs,
   input  logic [4:0]       IF_ID_rt,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_rt,
   input  logic             EX_MEM_BranchTaken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             Hazard,
   output logic             IF_Flush,
   output logic             ID_EX_Flush,
   output logic             pipe_freeze,
   output logic             mem_timeout,
   output logic [1:0]       state_out
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0] load_stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] freeze_cnt
`endif
);

   localparam int              WAIT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
      $error("hazard_ctrl: FLUSH_CYCLES must be in 1..7");
   end
   if (MEM_TIMEOUT < 1) begin : g_bad_mem_timeout
      $error("hazard_ctrl: MEM_TIMEOUT must be at least 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("hazard_ctrl: CNT_W must be at least 1");
   end

   state_e            state_r, state_nxt;
   logic [2:0]        flush_left_r, flush_left_nxt;
   logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt;

   logic load_use;
   logic mem_busy;

   logic pc_write_c, if_id_write_c, hazard_c, if_flush_c, id_ex_flush_c, freeze_c;

   load_use_detect u_load_use_detect (
      .opcode   (IF_ID_opcode),
      .rs       (IF_ID_rs),
      .rt       (IF_ID_rt),
      .mem_read (ID_EX_MemRead),
      .ex_rt    (ID_EX_rt),
      .load_use (load_use)
   );

   assign mem_busy = dmem_req && !dmem_ready;

   // Next-state and output decode. A freeze always wins because every
   // downstream register holds: whatever branch or load-use is visible now is
   // still visible once the access completes and is handled then.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      state_nxt      = state_r;
      flush_left_nxt = flush_left_r;
      wait_cnt_nxt   = wait_cnt_r;
      pc_write_c     = 1'b1;
      if_id_write_c  = 1'b1;
      hazard_c       = 1'b0;
      if_flush_c     = 1'b0;
      id_ex_flush_c  = 1'b0;
      freeze_c       = 1'b0;

      unique case (state_r)
         RUN, LOAD_STALL: begin
            state_nxt = RUN;
            if (mem_busy) begin
               freeze_c      = 1'b1;
               pc_write_c    = 1'b0;
               if_id_write_c = 1'b0;
               state_nxt     = MEM_WAIT;
               wait_cnt_nxt  = WAIT_W'(1);
            end else if (EX_MEM_BranchTaken) begin
               if_flush_c    = 1'b1;
               id_ex_flush_c = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_nxt      = FLUSH;
                  flush_left_nxt = FLUSH_INIT;
               end
            end else if (load_use && (state_r == RUN)) begin
               // The stall cycle that follows ignores load_use, so each load
               // costs exactly one bubble even though the hazard is still
               // visible while the load moves to MEM.
               hazard_c      = 1'b1;
               pc_write_c    = 1'b0;
               if_id_write_c = 1'b0;
               state_nxt     = LOAD_STALL;
            end
         end

         FLUSH: begin
            if (mem_busy) begin
               // The pending flush count is kept and resumed after the wait.
               freeze_c      = 1'b1;
               pc_write_c    = 1'b0;
               if_id_write_c = 1'b0;
               state_nxt     = MEM_WAIT;
               wait_cnt_nxt  = WAIT_W'(1);
            end else begin
               if_flush_c    = 1'b1;
               id_ex_flush_c = 1'b1;
               if (flush_left_r <= 3'd1) begin
                  flush_left_nxt = 3'd0;
                  state_nxt      = RUN;
               end else begin
                  flush_left_nxt = flush_left_r - 3'd1;
               end
            end
         end

         MEM_WAIT: begin
            if (dmem_ready) begin
               // Freeze drops in the completion cycle itself.
               state_nxt = (flush_left_r != 3'd0) ? FLUSH : RUN;
            end else begin
               freeze_c      = 1'b1;
               pc_write_c    = 1'b0;
               if_id_write_c = 1'b0;
               if (wait_cnt_r < WAIT_MAX) begin
                  wait_cnt_nxt = wait_cnt_r + 1'b1;
               end
            end
         end

         default: state_nxt = RUN;
      endcase
   end

   // Reset is asynchronous and inputs may be toggling while it is held, so the
   // outputs are forced to their idle values directly rather than relying on
   // the state register alone.
   assign PCWrite     = pc_write_c    | reset;
   assign IF_ID_Write = if_id_write_c | reset;
   assign Hazard      = hazard_c      & ~reset;
   assign IF_Flush    = if_flush_c    & ~reset;
   assign ID_EX_Flush = id_ex_flush_c & ~reset;
   assign pipe_freeze = freeze_c      & ~reset;
   assign state_out   = state_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= RUN;
         flush_left_r <= 3'd0;
         wait_cnt_r   <= '0;
         mem_timeout  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         state_r      <= state_nxt;
         flush_left_r <= flush_left_nxt;
         wait_cnt_r   <= wait_cnt_nxt;
         // Sticky: set when the wait count reaches the limit; the wait itself
         // continues until the memory answers.
         if ((state_nxt == MEM_WAIT) && (wait_cnt_nxt == WAIT_MAX)) begin
            mem_timeout <= 1'b1;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_stall_cnt <= '0;
         flush_cnt      <= '0;
         freeze_cnt     <= '0;
      end else begin
         if (Hazard && (load_stall_cnt != CNT_MAX)) begin
            load_stall_cnt <= load_stall_cnt + 1'b1;
         end
         if (IF_Flush && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
         if (pipe_freeze && (freeze_cnt != CNT_MAX)) begin
            freeze_cnt <= freeze_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. A behavioural model tracks the pipeline
// situation as plain counters (flush cycles still owed, memory wait length,
// whether the last cycle was a load bubble) and predicts every output each
// cycle. Directed scenarios come first, then randomized traffic.
// Build with HAZARD_STATS_EN defined to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int FLUSH_CYCLES = 2;
   localparam int MEM_TIMEOUT  = 64;
   localparam int CNT_W        = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [5:0]       IF_ID_opcode;
   logic [4:0]       IF_ID_rs;
   logic [4:0]       IF_ID_rt;
   logic             ID_EX_MemRead;
   logic [4:0]       ID_EX_rt;
   logic             EX_MEM_BranchTaken;
   logic             dmem_req;
   logic             dmem_ready;
   logic             PCWrite;
   logic             IF_ID_Write;
   logic             Hazard;
   logic             IF_Flush;
   logic             ID_EX_Flush;
   logic             pipe_freeze;
   logic             mem_timeout;
   logic [1:0]       state_out;
`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] load_stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] freeze_cnt;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(
      .FLUSH_CYCLES (FLUSH_CYCLES),
      .MEM_TIMEOUT  (MEM_TIMEOUT),
      .CNT_W        (CNT_W)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .IF_ID_opcode       (IF_ID_opcode),
      .IF_ID_rs           (IF_ID_rs),
      .IF_ID_rt           (IF_ID_rt),
      .ID_EX_MemRead      (ID_EX_MemRead),
      .ID_EX_rt           (ID_EX_rt),
      .EX_MEM_BranchTaken (EX_MEM_BranchTaken),
      .dmem_req           (dmem_req),
      .dmem_ready         (dmem_ready),
      .PCWrite            (PCWrite),
      .IF_ID_Write        (IF_ID_Write),
      .Hazard             (Hazard),
      .IF_Flush           (IF_Flush),
      .ID_EX_Flush        (ID_EX_Flush),
      .pipe_freeze        (pipe_freeze),
      .mem_timeout        (mem_timeout),
      .state_out          (state_out)
`ifdef HAZARD_STATS_EN
      ,
      .load_stall_cnt     (load_stall_cnt),
      .flush_cnt          (flush_cnt),
      .freeze_cnt         (freeze_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model of the pipeline situation.
   int m_flush_owed;   // flush cycles still to apply after the branch cycle
   int m_wait_len;     // cycles the pipeline has been frozen so far
   bit m_frozen;       // waiting on data memory
   bit m_bubbled;      // previous cycle inserted the load-use bubble
   bit m_timeout;
   int m_n_hazard, m_n_flush, m_n_freeze;

   // Last sampled DUT outputs, for directed scenario checks.
   bit s_pc, s_ifid, s_hz, s_iff, s_idf, s_fz, s_to;
   int s_state;

   logic [5:0] ops [6] = '{6'h00, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h23};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_load_use();
      bit reads_rt;
      reads_rt = (IF_ID_opcode == 6'h00) || (IF_ID_opcode == 6'h2B) ||
                 (IF_ID_opcode == 6'h04) || (IF_ID_opcode == 6'h05);
      if (!ID_EX_MemRead || ID_EX_rt == 5'd0) return 1'b0;
      return (ID_EX_rt == IF_ID_rs) || (reads_rt && ID_EX_rt == IF_ID_rt);
   endfunction

   function automatic void m_reset();
      m_flush_owed = 0;
      m_wait_len   = 0;
      m_frozen     = 0;
      m_bubbled    = 0;
      m_timeout    = 0;
      m_n_hazard   = 0;
      m_n_flush    = 0;
      m_n_freeze   = 0;
   endfunction

   task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input bit mr, input logic [4:0] ex_rt, input bit br,
                         input bit req, input bit rdy);
      IF_ID_opcode       = op;
      IF_ID_rs           = rs;
      IF_ID_rt           = rt;
      ID_EX_MemRead      = mr;
      ID_EX_rt           = ex_rt;
      EX_MEM_BranchTaken = br;
      dmem_req           = req;
      dmem_ready         = rdy;
   endtask

   task automatic idle();
      set_in(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Called at a falling edge with inputs already driven: checks the DUT
   // against the model for this cycle, advances the model past the coming
   // rising edge, and returns at the next falling edge.
   task automatic tick();
      bit busy, lu;
      bit e_pc, e_ifid, e_hz, e_iff, e_idf, e_fz, e_to;
      int e_state, e_nh, e_nf, e_nz;
      bit bubble_now;
      #2;
      s_pc = PCWrite; s_ifid = IF_ID_Write; s_hz = Hazard; s_iff = IF_Flush;
      s_idf = ID_EX_Flush; s_fz = pipe_freeze; s_to = mem_timeout; s_state = int'(state_out);

      e_pc = 1; e_ifid = 1; e_hz = 0; e_iff = 0; e_idf = 0; e_fz = 0;
      bubble_now = 0;
      if (reset) begin
         m_reset();
         e_state = 0;
      end
      e_to = m_timeout;
      e_nh = m_n_hazard; e_nf = m_n_flush; e_nz = m_n_freeze;

      if (!reset) begin
         busy = dmem_req && !dmem_ready;
         lu   = ref_load_use();
         e_state = m_frozen ? 3 : (m_flush_owed > 0) ? 2 : m_bubbled ? 1 : 0;
         if (m_frozen) begin
            if (dmem_ready) begin
               m_frozen = 0;
            end else begin
               e_fz = 1; e_pc = 0; e_ifid = 0;
               if (m_wait_len < MEM_TIMEOUT) m_wait_len++;
               if (m_wait_len == MEM_TIMEOUT) m_timeout = 1;
            end
         end else if (busy) begin
            e_fz = 1; e_pc = 0; e_ifid = 0;
            m_frozen   = 1;
            m_wait_len = 1;
            if (m_wait_len >= MEM_TIMEOUT) m_timeout = 1;
         end else if (m_flush_owed > 0) begin
            e_iff = 1; e_idf = 1;
            m_flush_owed--;
         end else if (EX_MEM_BranchTaken) begin
            e_iff = 1; e_idf = 1;
            m_flush_owed = FLUSH_CYCLES - 1;
         end else if (lu && !m_bubbled) begin
            e_hz = 1; e_pc = 0; e_ifid = 0;
            bubble_now = 1;
         end
         m_bubbled = bubble_now;
         m_n_hazard += int'(e_hz);
         m_n_flush  += int'(e_iff);
         m_n_freeze += int'(e_fz);
      end

      check("PCWrite",     PCWrite,     e_pc);
      check("IF_ID_Write", IF_ID_Write, e_ifid);
      check("Hazard",      Hazard,      e_hz);
      check("IF_Flush",    IF_Flush,    e_iff);
      check("ID_EX_Flush", ID_EX_Flush, e_idf);
      check("pipe_freeze", pipe_freeze, e_fz);
      check("mem_timeout", mem_timeout, e_to);
      check("state_out",   state_out,   e_state);
`ifdef HAZARD_STATS_EN
      check("load_stall_cnt", load_stall_cnt, e_nh);
      check("flush_cnt",      flush_cnt,      e_nf);
      check("freeze_cnt",     freeze_cnt,     e_nz);
`endif
      @(negedge clk);
   endtask

   initial begin
      int n_fz;
      m_reset();
      idle();
      reset = 1'b1;
      @(negedge clk);

      // Reset state.
      tick();
      check("rst_state", s_state, 0);
      check("rst_pcwrite", s_pc, 1);
      tick();
      reset = 1'b0;
      tick();

      // lw $2 followed by add using $2 as rs: one bubble, then stall state.
      set_in(6'h00, 5'd2, 5'd7, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
      tick();
      check("lu_add_hazard", s_hz, 1);
      check("lu_add_pc", s_pc, 0);
      check("lu_add_ifid", s_ifid, 0);
      check("lu_add_state0", s_state, 0);
      tick();
      check("lu_stall_hazard", s_hz, 0);
      check("lu_stall_state1", s_state, 1);
      idle();
      tick();
      check("lu_back_run", s_state, 0);

      // Load into $zero never stalls.
      set_in(6'h00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      check("lu_r0_hazard", s_hz, 0);
      // addi writes rt, so rt matching the load is not a dependency.
      set_in(6'h08, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      tick();
      check("lu_addi_hazard", s_hz, 0);
      // sw reads rt as store data.
      set_in(6'h2B, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      tick();
      check("lu_sw_hazard", s_hz, 1);
      tick();
      idle();
      tick();

      // Taken branch: two flush cycles, PC written throughout.
      set_in(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      check("br_flush1", s_iff, 1);
      check("br_pc1", s_pc, 1);
      idle();
      tick();
      check("br_flush2", s_idf, 1);
      check("br_state2", s_state, 2);
      tick();
      check("br_done", s_iff, 0);
      check("br_state_run", s_state, 0);

      // Five busy cycles then ready.
      n_fz = 0;
      set_in(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         n_fz += int'(s_fz);
      end
      check("mem5_freeze_cycles", n_fz, 5);
      dmem_ready = 1'b1;
      tick();
      check("mem5_ready_freeze", s_fz, 0);
      idle();
      tick();

      // Long wait: flag rises exactly when the wait reaches MEM_TIMEOUT.
      set_in(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= MEM_TIMEOUT + 2; i++) begin
         tick();
         if (i == MEM_TIMEOUT) check("timeout_early", s_to, 0);
         if (i == MEM_TIMEOUT + 1) check("timeout_set", s_to, 1);
      end
      dmem_ready = 1'b1;
      tick();
      idle();
      tick();
      tick();
      check("timeout_sticky", s_to, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      // Freeze, branch and load-use together: freeze first, then the still
      // visible branch is flushed and no bubble is ever inserted.
      set_in(6'h00, 5'd2, 5'd0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
      tick();
      check("combo_freeze", s_fz, 1);
      check("combo_no_hz0", s_hz, 0);
      tick();
      tick();
      dmem_ready = 1'b1;
      tick();
      check("combo_ready_nofz", s_fz, 0);
      dmem_req = 1'b0;
      dmem_ready = 1'b0;
      tick();
      check("combo_flush", s_iff, 1);
      check("combo_no_hz1", s_hz, 0);
      EX_MEM_BranchTaken = 1'b0;
      tick();
      check("combo_flush2", s_idf, 1);
      check("combo_no_hz2", s_hz, 0);
      idle();
      tick();

      // Reset asserted while flushing.
      set_in(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      #3;
      reset = 1'b1;
      #1;
      check("rstf_state", state_out, 0);
      check("rstf_iff", IF_Flush, 0);
      check("rstf_idf", ID_EX_Flush, 0);
      check("rstf_to", mem_timeout, 0);
      check("rstf_pc", PCWrite, 1);
`ifdef HAZARD_STATS_EN
      check("rstf_lsc", load_stall_cnt, 0);
      check("rstf_flc", flush_cnt, 0);
      check("rstf_fzc", freeze_cnt, 0);
`endif
      m_reset();
      @(negedge clk);
      tick();
      reset = 1'b0;

      // Randomized traffic with small register numbers to provoke matches.
      for (int i = 0; i < 3000; i++) begin
         set_in(ops[$urandom_range(0, 5)],
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) < 2), ($urandom_range(0, 3) == 0));
         reset = ($urandom_range(0, 499) == 0);
         tick();
      end
      reset = 1'b0;
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It detects load-use hazards between the ID and EX stages, flushes wrong-path instructions after a taken branch, and freezes the whole pipeline while a multi-cycle data-memory access is outstanding. It drives the ID-stage Hazard input (control-bit zeroing), the PC and IF/ID write enables, and the stage flush and freeze strobes.

Parameters:
FLUSH_CYCLES, 2, number of cycles IF/ID and ID/EX are flushed after a taken branch (1..7).
MEM_TIMEOUT, 64, maximum cycles in MEM_WAIT before mem_timeout is raised.
CNT_W, 32, width of stall statistics counters.

Ports:
clk  in  1  clock.
reset  in  1  reset, asynchronous, active-high.
IF_ID_opcode  in  6  opcode of the instruction in ID.
IF_ID_rs  in  5  rs field of the instruction in ID.
IF_ID_rt  in  5  rt field of the instruction in ID.
ID_EX_MemRead  in  1  instruction in EX is a load.
ID_EX_rt  in  5  load destination register in EX.
EX_MEM_BranchTaken  in  1  branch resolved taken in MEM.
dmem_req  in  1  data memory access active this cycle.
dmem_ready  in  1  data memory completes this cycle.
PCWrite  out  1  PC update enable.
IF_ID_Write  out  1  IF/ID register load enable.
Hazard  out  1  to ID control unit; forces CTR_bits to 0 (bubble).
IF_Flush  out  1  clear IF/ID to NOP.
ID_EX_Flush  out  1  clear ID/EX to bubble.
pipe_freeze  out  1  hold all pipeline registers (ID/EX, EX/MEM, MEM/WB).
mem_timeout  out  1  sticky error flag.
state_out  out  2  current FSM state encoding.

Behaviour:
- States: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3. State and counters are registered; outputs are combinational from the state plus current inputs.
- Reset (async): state=RUN, flush counter=0, wait counter=0, mem_timeout=0. During reset: PCWrite=1, IF_ID_Write=1, and all other outputs 0.
- load_use = ID_EX_MemRead && ID_EX_rt!=0 && (ID_EX_rt==IF_ID_rs || (uses_rt && ID_EX_rt==IF_ID_rt)). uses_rt is 1 for opcode 0x00 (R-type), 0x2B (sw), 0x04 (beq), and 0x05 (bne).
- Event priority, evaluated in RUN: mem_busy (dmem_req && !dmem_ready) > EX_MEM_BranchTaken > load_use.
- RUN, no event: PCWrite=1, IF_ID_Write=1, all others 0.
- RUN, mem_busy: pipe_freeze=1, PCWrite=0, IF_ID_Write=0. Next state MEM_WAIT, wait counter=1. A branch or load-use present in the same cycle is not acted on; it is re-evaluated after the freeze, because the registers hold.
- RUN, branch taken: IF_Flush=1, ID_EX_Flush=1, PCWrite=1 (target is loaded). If FLUSH_CYCLES>1, next state is FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
- RUN, load_use: Hazard=1, PCWrite=0, IF_ID_Write=0. Next state LOAD_STALL.
- LOAD_STALL (exactly 1 cycle): all outputs at their RUN defaults, and load_use is ignored, guaranteeing exactly one bubble per load. Next state RUN. If mem_busy occurs here, go to MEM_WAIT with a freeze. If a branch is taken here, apply the flush as in RUN.
- FLUSH: IF_Flush=1, ID_EX_Flush=1, PCWrite=1, IF_ID_Write=1, and the counter decrements. Move to RUN when the counter reaches 1. mem_busy overrides: freeze and go to MEM_WAIT; the remaining flush count is kept and resumed afterwards.
- MEM_WAIT: pipe_freeze=1, PCWrite=0, IF_ID_Write=0, and the wait counter increments, saturating at MEM_TIMEOUT. On dmem_ready=1 the freeze drops in that same cycle, and the next state is FLUSH if a flush count is pending, otherwise RUN. When the counter reaches MEM_TIMEOUT, mem_timeout is set; it stays set until reset and does not abort the wait.

Optional Feature:
HAZARD_STATS_EN.
- Defined: adds outputs load_stall_cnt, flush_cnt, freeze_cnt (each CNT_W bits). They increment on the Hazard=1, IF_Flush=1 and pipe_freeze=1 cycles respectively, saturate at all-ones, and clear on reset.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

Decomposition:
- hazard_pkg: state encoding constants (RUN, LOAD_STALL, FLUSH, MEM_WAIT); opcode constants OP_RTYPE=6'h00, OP_SW=6'h2B, OP_BEQ=6'h04, OP_BNE=6'h05, OP_LW=6'h23.
- Sub-module load_use_detect: combinational, producing the uses_rt decode and the load_use term. It is instantiated once.

Test Plan:
- lw $2 in EX (MemRead=1, rt=2), ID add with rs=2 -> one cycle Hazard=1, PCWrite=0, IF_ID_Write=0; next cycle RUN defaults, state 1 then 0.
- lw rt=0 in EX, ID rs=0 -> no stall. lw rt=5, ID addi (opcode 0x08) with rt=5 -> no stall. lw rt=5, ID sw with rt=5 -> stall.
- BranchTaken pulse with FLUSH_CYCLES=2 -> IF_Flush and ID_EX_Flush high for 2 cycles, PCWrite=1 throughout, then RUN.
- dmem_req=1, dmem_ready=0 for 5 cycles, then 1 -> pipe_freeze high for 5 cycles and low in the ready cycle. Repeat with ready withheld past 64 cycles -> mem_timeout=1, remaining set until reset.
- BranchTaken, load_use and mem_busy in the same cycle -> freeze first; after ready, flush is applied and no Hazard pulse occurs.
- reset asserted in FLUSH with counter mid-count -> immediately state_out=0, all flushes 0, mem_timeout 0; with HAZARD_STATS_EN, counters read 0.
